// File: rtl/mipi_dphy_tx_lanes_if.sv
// Word-stream interface between the CSI packetizer and the D-PHY lane
// sequencer.
//   in_valid  : a word is available
//   in_ready  : the sequencer takes the word when in_valid & in_ready
//   in_data   : lane k byte in in_data[8k+7:8k]
//   in_last   : final word of the burst
// Modports:
//   master : the packetizer side (drives valid/data/last)
//   slave  : the sequencer side (drives ready)
interface mipi_dphy_tx_lanes_if #(
    parameter int NUM_DATA_LANES = 2
);
    logic                          in_valid;
    logic                          in_ready;
    logic [8*NUM_DATA_LANES-1:0]   in_data;
    logic                          in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/mipi_dphy_tx_lanes.sv
// Multi-lane MIPI D-PHY transmit sequencer.
// All data lanes share one state machine. The block runs the
// LP11 -> LP01 -> LP00 -> HS-zero -> sync -> payload -> trail -> LP11 burst
// sequence and drives the clock-lane HS enable. HS bytes go to a downstream
// serializer LSB first.
//
// Ports:
//   clk_hs     in   byte clock; all logic runs on its rising edge
//   reset      in   synchronous, active-high
//   enable     in   a burst may start (looked at in ST_STOP only)
//   in_bus     if   word stream (valid/ready/data/last), slave side
//   hs_en      out  data-lane HS driver enable
//   hs_data    out  per-lane HS byte, lane k in [8k+7:8k]
//   lp_p/lp_n  out  per-lane LP levels (all lanes identical)
//   clk_hs_en  out  clock-lane HS enable
//   busy       out  sequencer is not in ST_STOP
//   underrun   out  one-cycle pulse when the stream ran dry in ST_HST
//
// Every output except in_ready comes from a register loaded from the
// current state. The line levels therefore show each state one cycle after
// the state register enters it. This is the 1-cycle word-to-wire latency
// of ST_HST: an accepted word appears on hs_data on the next edge.
module mipi_dphy_tx_lanes #(
    parameter int NUM_DATA_LANES = 2,
    parameter int TW             = 8,
    parameter int T_LPX          = 4,
    parameter int T_HS_PREPARE   = 3,
    parameter int T_HS_ZERO      = 6,
    parameter int T_HS_TRAIL     = 5,
    parameter int T_HS_EXIT      = 4,
    parameter int CONT_CLK       = 0
) (
    input  logic                          clk_hs,
    input  logic                          reset,
    input  logic                          enable,
    mipi_dphy_tx_lanes_if.slave           in_bus,
    output logic                          hs_en,
    output logic [8*NUM_DATA_LANES-1:0]   hs_data,
    output logic [NUM_DATA_LANES-1:0]     lp_p,
    output logic [NUM_DATA_LANES-1:0]     lp_n,
    output logic                          clk_hs_en,
    output logic                          busy,
    output logic                          underrun
);
    localparam int         WB        = 8 * NUM_DATA_LANES;
    localparam logic [7:0] SYNC_BYTE = 8'hB8;
    localparam logic       CLK_ALWAYS = (CONT_CLK != 0);

    typedef enum logic [2:0] {
        ST_STOP,
        ST_HS_RQST,
        ST_HS_PRPR,
        ST_HS_ZERO,
        ST_SYNC,
        ST_HST,
        ST_TRAIL,
        ST_EXIT
    } state_t;

    state_t                    state_reg, state_next;
    logic [TW-1:0]             timer_reg, timer_next;
    logic                      accept;
    logic                      underrun_now;

    logic                      hs_en_reg, hs_en_next;
    logic [WB-1:0]             hs_data_reg, hs_data_next;
    logic [NUM_DATA_LANES-1:0] lp_p_reg, lp_p_next;
    logic [NUM_DATA_LANES-1:0] lp_n_reg, lp_n_next;
    logic                      clk_en_reg, clk_en_next;
    logic                      busy_reg, busy_next;
    logic                      underrun_reg;
    // Per lane: inverse of bit 7 of the last byte placed on the wire, which
    // is the trail fill level for that lane.
    logic [NUM_DATA_LANES-1:0] trail_inv_reg, trail_inv_next;

    // A timed state loads T-1 on entry and leaves when the timer reads zero,
    // so it lasts exactly T cycles.
    function automatic logic [TW-1:0] entry_load(input state_t s);
        logic [TW-1:0] v;
        v = '0;
        case (s)
            ST_HS_RQST: v = TW'(T_LPX - 1);
            ST_HS_PRPR: v = TW'(T_HS_PREPARE - 1);
            ST_HS_ZERO: v = TW'(T_HS_ZERO - 1);
            ST_TRAIL:   v = TW'(T_HS_TRAIL - 1);
            ST_EXIT:    v = TW'(T_HS_EXIT - 1);
            default:    v = '0;
        endcase
        return v;
    endfunction

    // ---------------- state register ----------------
    always_ff @(posedge clk_hs) begin
        if (reset) begin
            state_reg <= ST_STOP;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_next   = state_reg;
        accept       = 1'b0;
        underrun_now = 1'b0;
        case (state_reg)
            ST_STOP:    if (enable && in_bus.in_valid) state_next = ST_HS_RQST;
            ST_HS_RQST: if (timer_reg == '0) state_next = ST_HS_PRPR;
            ST_HS_PRPR: if (timer_reg == '0) state_next = ST_HS_ZERO;
            ST_HS_ZERO: if (timer_reg == '0) state_next = ST_SYNC;
            ST_SYNC:    state_next = ST_HST;
            ST_HST: begin
                if (in_bus.in_valid) begin
                    accept = 1'b1;
                    if (in_bus.in_last) state_next = ST_TRAIL;
                end else begin
                    // A gap inside a burst cannot be bridged; close it out.
                    underrun_now = 1'b1;
                    state_next   = ST_TRAIL;
                end
            end
            ST_TRAIL:   if (timer_reg == '0) state_next = ST_EXIT;
            ST_EXIT:    if (timer_reg == '0) state_next = ST_STOP;
            default:    state_next = ST_STOP;
        endcase

        if (state_next != state_reg) begin
            timer_next = entry_load(state_next);
        end else if (timer_reg != '0) begin
            timer_next = timer_reg - 1'b1;
        end else begin
            timer_next = timer_reg;
        end
    end

    assign in_bus.in_ready = (state_reg == ST_HST);

    // ---------------- output datapath ----------------
    always_comb begin
        hs_en_next  = (state_reg == ST_HS_ZERO) || (state_reg == ST_SYNC) ||
                      (state_reg == ST_HST)     || (state_reg == ST_TRAIL);
        // LP lines are 00 in every HS state, so only STOP/EXIT/RQST drive 1s.
        lp_p_next   = {NUM_DATA_LANES{(state_reg == ST_STOP) || (state_reg == ST_EXIT)}};
        lp_n_next   = {NUM_DATA_LANES{(state_reg == ST_STOP) || (state_reg == ST_EXIT) ||
                                      (state_reg == ST_HS_RQST)}};
        busy_next   = (state_reg != ST_STOP);
        clk_en_next = CLK_ALWAYS || (state_reg != ST_STOP);
    end

    for (genvar gi = 0; gi < NUM_DATA_LANES; gi++) begin : g_lane
        logic [7:0] lane_fill;
        logic [7:0] lane_in;

        assign lane_fill = {8{trail_inv_reg[gi]}};
        assign lane_in   = in_bus.in_data[8*gi +: 8];

        // The sync byte has bit 7 set, so a burst that ends before any word
        // is accepted trails with 0x00.
        assign trail_inv_next[gi] = (state_reg == ST_SYNC) ? 1'b0 :
                                    accept                 ? ~lane_in[7] :
                                                             trail_inv_reg[gi];

        // The underrun cycle of ST_HST already puts the trail fill out, so
        // the wire never repeats a stale payload byte.
        assign hs_data_next[8*gi +: 8] =
            (state_reg == ST_HS_ZERO)                          ? 8'h00     :
            (state_reg == ST_SYNC)                             ? SYNC_BYTE :
            accept                                             ? lane_in   :
            ((state_reg == ST_HST) || (state_reg == ST_TRAIL)) ? lane_fill :
                                                                 hs_data_reg[8*gi +: 8];
    end

    always_ff @(posedge clk_hs) begin
        if (reset) begin
            hs_en_reg     <= 1'b0;
            hs_data_reg   <= '0;
            lp_p_reg      <= '1;
            lp_n_reg      <= '1;
            clk_en_reg    <= CLK_ALWAYS;
            busy_reg      <= 1'b0;
            underrun_reg  <= 1'b0;
            trail_inv_reg <= '0;
        end else begin
            hs_en_reg     <= hs_en_next;
            hs_data_reg   <= hs_data_next;
            lp_p_reg      <= lp_p_next;
            lp_n_reg      <= lp_n_next;
            clk_en_reg    <= clk_en_next;
            busy_reg      <= busy_next;
            underrun_reg  <= underrun_now;
            trail_inv_reg <= trail_inv_next;
        end
    end

    assign hs_en     = hs_en_reg;
    assign hs_data   = hs_data_reg;
    assign lp_p      = lp_p_reg;
    assign lp_n      = lp_n_reg;
    assign clk_hs_en = clk_en_reg;
    assign busy      = busy_reg;
    assign underrun  = underrun_reg;
endmodule

// File: tb/tb_mipi_dphy_tx_lanes.sv
module tb_mipi_dphy_tx_lanes;
    localparam int N            = 2;
    localparam int WB           = 8 * N;
    localparam int T_LPX        = 4;
    localparam int T_HS_PREPARE = 3;
    localparam int T_HS_ZERO    = 6;
    localparam int T_HS_TRAIL   = 5;
    localparam int T_HS_EXIT    = 4;

    logic clk_hs = 1'b0;
    always #5 clk_hs = ~clk_hs;

    logic reset;
    logic enable;

    mipi_dphy_tx_lanes_if #(.NUM_DATA_LANES(N)) bus ();
    mipi_dphy_tx_lanes_if #(.NUM_DATA_LANES(N)) bus2 ();

    assign bus2.in_valid = bus.in_valid;
    assign bus2.in_data  = bus.in_data;
    assign bus2.in_last  = bus.in_last;

    logic          hs_en, clk_hs_en, busy, underrun;
    logic [WB-1:0] hs_data;
    logic [N-1:0]  lp_p, lp_n;

    logic          hs_en2, clk_hs_en2, busy2, underrun2;
    logic [WB-1:0] hs_data2;
    logic [N-1:0]  lp_p2, lp_n2;

    mipi_dphy_tx_lanes #(
        .NUM_DATA_LANES(N), .TW(8), .T_LPX(T_LPX), .T_HS_PREPARE(T_HS_PREPARE),
        .T_HS_ZERO(T_HS_ZERO), .T_HS_TRAIL(T_HS_TRAIL), .T_HS_EXIT(T_HS_EXIT),
        .CONT_CLK(0)
    ) dut (
        .clk_hs(clk_hs), .reset(reset), .enable(enable), .in_bus(bus.slave),
        .hs_en(hs_en), .hs_data(hs_data), .lp_p(lp_p), .lp_n(lp_n),
        .clk_hs_en(clk_hs_en), .busy(busy), .underrun(underrun)
    );

    // Same stimulus, continuous clock lane.
    mipi_dphy_tx_lanes #(
        .NUM_DATA_LANES(N), .TW(8), .T_LPX(T_LPX), .T_HS_PREPARE(T_HS_PREPARE),
        .T_HS_ZERO(T_HS_ZERO), .T_HS_TRAIL(T_HS_TRAIL), .T_HS_EXIT(T_HS_EXIT),
        .CONT_CLK(1)
    ) dut_cc (
        .clk_hs(clk_hs), .reset(reset), .enable(enable), .in_bus(bus2.slave),
        .hs_en(hs_en2), .hs_data(hs_data2), .lp_p(lp_p2), .lp_n(lp_n2),
        .clk_hs_en(clk_hs_en2), .busy(busy2), .underrun(underrun2)
    );

    // Expected wire state for one cycle.
    typedef struct packed {
        logic          busy;
        logic          hs_en;
        logic          lp_p;
        logic          lp_n;
        logic          und;
        logic          ck;
        logic          chk_d;
        logic [WB-1:0] d;
    } rec_t;

    typedef struct packed {
        logic [WB-1:0] d;
        logic          l;
    } stim_t;

    rec_t  exp_q[$];
    stim_t stim_q[$];
    logic [WB-1:0] cur_words[$];

    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;
    bit  active = 1'b0;
    int  rdy_cnt = 0;
    int  busy_cnt = 0;
    int  exp_rdy = 0;
    int  exp_busy = 0;

    function automatic rec_t mk(input logic b, input logic h, input logic p, input logic n,
                                input logic u, input logic c, input logic cd,
                                input logic [WB-1:0] d);
        rec_t r;
        r.busy = b; r.hs_en = h; r.lp_p = p; r.lp_n = n;
        r.und = u; r.ck = c; r.chk_d = cd; r.d = d;
        return r;
    endfunction

    // Reference model: the wire picture of one burst, from LP01 through the
    // following LP11 stop cycle.
    function automatic void model_burst(input bit drop);
        logic [WB-1:0] last_w;
        logic [WB-1:0] fill;
        int hs_cycles;
        for (int i = 0; i < T_LPX; i++)        exp_q.push_back(mk(1, 0, 0, 1, 0, 1, 0, '0));
        for (int i = 0; i < T_HS_PREPARE; i++) exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 0, '0));
        for (int i = 0; i < T_HS_ZERO; i++)    exp_q.push_back(mk(1, 1, 0, 0, 0, 1, 1, '0));
        exp_q.push_back(mk(1, 1, 0, 0, 0, 1, 1, {N{8'hB8}}));
        foreach (cur_words[i]) exp_q.push_back(mk(1, 1, 0, 0, 0, 1, 1, cur_words[i]));
        last_w = (cur_words.size() > 0) ? cur_words[cur_words.size()-1] : {N{8'hB8}};
        for (int k = 0; k < N; k++) fill[8*k +: 8] = last_w[8*k+7] ? 8'h00 : 8'hFF;
        if (drop) exp_q.push_back(mk(1, 1, 0, 0, 1, 1, 1, fill));
        for (int i = 0; i < T_HS_TRAIL; i++)   exp_q.push_back(mk(1, 1, 0, 0, 0, 1, 1, fill));
        for (int i = 0; i < T_HS_EXIT; i++)    exp_q.push_back(mk(1, 0, 1, 1, 0, 1, 0, '0));
        exp_q.push_back(mk(0, 0, 1, 1, 0, 0, 0, '0));
        hs_cycles = cur_words.size() + (drop ? 1 : 0);
        exp_rdy  += hs_cycles;
        exp_busy += T_LPX + T_HS_PREPARE + T_HS_ZERO + 1 + hs_cycles + T_HS_TRAIL + T_HS_EXIT;
    endfunction

    // Queue a burst of nw words (random unless fixed_w is used) for the driver
    // and the scoreboard.
    task automatic add_burst(input int nw, input bit drop, input bit use_fixed,
                             input logic [WB-1:0] fixed_w);
        stim_t s;
        cur_words.delete();
        for (int i = 0; i < nw; i++) begin
            s.d = use_fixed ? fixed_w : WB'($urandom);
            s.l = (!drop && i == nw - 1);
            stim_q.push_back(s);
            cur_words.push_back(s.d);
        end
        model_burst(drop);
        $display("burst words=%0d drop=%0d", nw, drop);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Present the queued words; a word advances only when accepted.
    task automatic drive(input bit kill_enable);
        int idx;
        int cyc;
        bit acc;
        idx = 0;
        cyc = 0;
        rdy_cnt = 0;
        busy_cnt = 0;
        while (idx < stim_q.size() && cyc < 500) begin
            bus.in_valid = 1'b1;
            bus.in_data  = stim_q[idx].d;
            bus.in_last  = stim_q[idx].l;
            @(negedge clk_hs);
            acc = bus.in_ready;
            @(posedge clk_hs);
            #1;
            cyc++;
            if (acc) idx++;
            if (kill_enable && cyc == 3) enable = 1'b0;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("accept_all", idx, stim_q.size());
        stim_q.delete();
        cyc = 0;
        while ((exp_q.size() != 0 || active) && cyc < 300) begin
            @(posedge clk_hs);
            #1;
            cyc++;
        end
        chk("drain", exp_q.size(), 0);
        exp_q.delete();
        chk("in_ready_cycles", rdy_cnt, exp_rdy);
        chk("busy_cycles", busy_cnt, exp_busy);
        exp_rdy = 0;
        exp_busy = 0;
        enable = 1'b1;
        repeat (2) @(posedge clk_hs);
        #1;
    endtask

    // Scoreboard monitor: starts on busy, compares one record per cycle.
    rec_t r_exp, r_obs;
    always @(negedge clk_hs) begin
        if (mon_en && !reset) begin
            if (bus.in_ready) rdy_cnt++;
            if (busy) busy_cnt++;
        end
        if (reset || !mon_en) begin
            active = 1'b0;
        end else begin
            if (!active && busy) active = 1'b1;
            if (active) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_cycle t=%0t busy=%b hs_en=%b want=empty", $time, busy, hs_en);
                    active = 1'b0;
                end else begin
                    r_exp = exp_q.pop_front();
                    if (!r_exp.chk_d) r_exp.d = '0;
                    r_obs.busy  = busy;
                    r_obs.hs_en = hs_en;
                    r_obs.lp_p  = (lp_p == {N{1'b1}}) ? 1'b1 : (lp_p == '0) ? 1'b0 : 1'bx;
                    r_obs.lp_n  = (lp_n == {N{1'b1}}) ? 1'b1 : (lp_n == '0) ? 1'b0 : 1'bx;
                    r_obs.und   = underrun;
                    r_obs.ck    = clk_hs_en;
                    r_obs.chk_d = r_exp.chk_d;
                    r_obs.d     = r_exp.chk_d ? hs_data : '0;
                    checks++;
                    if (r_obs !== r_exp) begin
                        errors++;
                        $display("FAIL wire t=%0t got busy=%b hs=%b lp=%b%b und=%b ck=%b d=%h want busy=%b hs=%b lp=%b%b und=%b ck=%b d=%h",
                                 $time, r_obs.busy, r_obs.hs_en, r_obs.lp_p, r_obs.lp_n, r_obs.und, r_obs.ck, r_obs.d,
                                 r_exp.busy, r_exp.hs_en, r_exp.lp_p, r_exp.lp_n, r_exp.und, r_exp.ck, r_exp.d);
                    end
                    checks++;
                    if (clk_hs_en2 !== 1'b1) begin
                        errors++;
                        $display("FAIL cont_clk t=%0t got=%b want=1", $time, clk_hs_en2);
                    end
                    if (exp_q.size() == 0) active = 1'b0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        bit drop;
        int cyc;
        reset = 1'b1;
        enable = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        repeat (3) @(posedge clk_hs);
        #1;
        reset = 1'b0;
        @(posedge clk_hs);
        #1;
        // Reset / idle state.
        chk("rst_hs_en", hs_en, 0);
        chk("rst_hs_data", hs_data, 0);
        chk("rst_lp_p", lp_p, {N{1'b1}});
        chk("rst_lp_n", lp_n, {N{1'b1}});
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_clk_hs_en", clk_hs_en, 0);
        chk("rst_clk_hs_en_cc", clk_hs_en2, 1);
        // No burst while enable is low.
        bus.in_valid = 1'b1;
        repeat (5) @(posedge clk_hs);
        #1;
        chk("no_start_disabled", busy, 0);
        bus.in_valid = 1'b0;
        mon_en = 1'b1;
        enable = 1'b1;

        // Single word {A5,3C}: lane0=3C -> fill FF, lane1=A5 -> fill 00.
        add_burst(1, 0, 1, 16'hA53C);
        drive(0);
        // Four-word burst.
        add_burst(4, 0, 0, '0);
        drive(0);
        // Underrun after two words.
        add_burst(2, 1, 0, '0);
        drive(0);
        // Back-to-back bursts with in_valid held throughout.
        add_burst(3, 0, 0, '0);
        add_burst(2, 0, 0, '0);
        add_burst(1, 0, 0, '0);
        drive(0);
        // Random bursts, some with enable dropped mid-burst.
        for (int it = 0; it < 8; it++) begin
            nw = $urandom_range(1, 6);
            drop = ($urandom_range(0, 3) == 0);
            add_burst(nw, drop, 0, '0);
            drive(it[0]);
        end

        // Reset in the middle of ST_HST.
        mon_en = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = WB'($urandom);
        bus.in_last  = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk_hs);
            cyc++;
        end while (!bus.in_ready && cyc < 100);
        chk("reach_hst", bus.in_ready, 1);
        reset = 1'b1;
        @(posedge clk_hs);
        #1;
        $display("reset during HS transfer");
        chk("midrst_hs_en", hs_en, 0);
        chk("midrst_lp_p", lp_p, {N{1'b1}});
        chk("midrst_lp_n", lp_n, {N{1'b1}});
        chk("midrst_in_ready", bus.in_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_clk_hs_en", clk_hs_en, 0);
        chk("midrst_clk_hs_en_cc", clk_hs_en2, 1);
        bus.in_valid = 1'b0;
        @(posedge clk_hs);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge clk_hs);
        #1;
        // Normal operation after the abort.
        add_burst(2, 0, 0, '0);
        drive(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
